// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier: op codes, FSM states and
// the radix legality check used at elaboration.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL   = 2'b00,
    MUL_OP_UMULL = 2'b01,
    MUL_OP_SMULL = 2'b10,
    MUL_OP_MLA   = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } mul_state_e;

  function automatic bit radix_ok(input int width, input int radix_bits);
    return ((radix_bits == 1) || (radix_bits == 2) || (radix_bits == 4)) &&
           ((width % radix_bits) == 0);
  endfunction

endpackage

// File: rtl/mul_unit_if.sv
// Request/result bundle between the core controller (master) and mul_unit (slave).
interface mul_unit_if #(
  parameter int WIDTH = 32
);
  import mul_pkg::*;

  logic             start;
  mul_op_e          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             flag_n;
  logic             flag_z;

  modport master (
    output start, op, a, b, acc,
    input  busy, done, result_lo, result_hi, flag_n, flag_z
  );

  modport slave (
    input  start, op, a, b, acc,
    output busy, done, result_lo, result_hi, flag_n, flag_z
  );

endinterface

// File: rtl/mul_step.sv
// One RUN-cycle partial-product accumulate: prod + (mcand * slice) << shift.
module mul_step #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic [WIDTH-1:0]           i_mcand,
  input  logic [RADIX_BITS-1:0]      i_slice,
  input  logic [$clog2(2*WIDTH)-1:0] i_shift,
  input  logic [2*WIDTH-1:0]         i_prod,
  output logic [2*WIDTH-1:0]         o_prod
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] w_pp;

  assign w_pp   = PW'(i_mcand) * PW'(i_slice);
  assign o_prod = i_prod + (w_pp << i_shift);

endmodule

// File: rtl/mul_unit.sv
// Iterative MUL/MLA/UMULL/SMULL unit, RADIX_BITS multiplier bits per cycle.
// Define MUL_EARLY_OUT_EN to leave RUN as soon as the remaining multiplier is zero.
module mul_unit
  import mul_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic clk,
  input  logic reset,
  mul_unit_if.slave mul_bus
);

  localparam int NSTEPS = WIDTH / RADIX_BITS;
  localparam int CNT_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam int SH_W   = $clog2(2 * WIDTH);

  if (!radix_ok(WIDTH, RADIX_BITS)) begin : g_bad_radix
    $error("mul_unit: RADIX_BITS must be 1, 2 or 4 and divide WIDTH");
  end

  mul_state_e         r_state;
  mul_op_e            r_op;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_prod;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic               r_n;
  logic               r_z;

  logic               w_is_smull;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [CNT_W-1:0]   w_idx;
  logic [SH_W-1:0]    w_shift;
  logic [WIDTH-1:0]   w_mplier_next;
  logic [2*WIDTH-1:0] w_prod_next;
  logic               w_last;
  logic               w_long;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_fix_lo;
  logic [WIDTH-1:0]   w_fix_hi;

  // Magnitudes for SMULL; negating the most-negative value yields 2^(W-1), which is correct unsigned.
  assign w_is_smull = (mul_bus.op == MUL_OP_SMULL);
  assign w_a_abs    = (w_is_smull && mul_bus.a[WIDTH-1]) ? -mul_bus.a : mul_bus.a;
  assign w_b_abs    = (w_is_smull && mul_bus.b[WIDTH-1]) ? -mul_bus.b : mul_bus.b;

  assign w_idx         = CNT_W'(NSTEPS - 1) - r_cnt;
  assign w_shift       = SH_W'(w_idx) * SH_W'(RADIX_BITS);
  assign w_mplier_next = r_mplier >> RADIX_BITS;

`ifdef MUL_EARLY_OUT_EN
  assign w_last = (r_cnt == '0) || (w_mplier_next == '0);
`else
  assign w_last = (r_cnt == '0);
`endif

  mul_step #(
    .WIDTH      (WIDTH),
    .RADIX_BITS (RADIX_BITS)
  ) u_step (
    .i_mcand (r_mcand),
    .i_slice (r_mplier[RADIX_BITS-1:0]),
    .i_shift (w_shift),
    .i_prod  (r_prod),
    .o_prod  (w_prod_next)
  );

  assign w_long     = (r_op == MUL_OP_UMULL) || (r_op == MUL_OP_SMULL);
  assign w_prod_fix = r_neg ? -r_prod : r_prod;
  assign w_fix_lo   = (r_op == MUL_OP_MLA) ? (w_prod_fix[WIDTH-1:0] + r_acc)
                                           : w_prod_fix[WIDTH-1:0];
  assign w_fix_hi   = w_long ? w_prod_fix[2*WIDTH-1:WIDTH] : '0;

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_op     <= MUL_OP_MUL;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (mul_bus.start) begin
            r_op     <= mul_bus.op;
            r_acc    <= mul_bus.acc;
            r_mcand  <= w_a_abs;
            r_mplier <= w_b_abs;
            r_neg    <= w_is_smull && (mul_bus.a[WIDTH-1] ^ mul_bus.b[WIDTH-1]);
            r_prod   <= '0;
            r_cnt    <= CNT_W'(NSTEPS - 1);
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_prod   <= w_prod_next;
          r_mplier <= w_mplier_next;
          if (w_last) r_state <= ST_FIX;
          else        r_cnt   <= r_cnt - 1'b1;
        end
        ST_FIX: begin
          r_lo    <= w_fix_lo;
          r_hi    <= w_fix_hi;
          r_n     <= w_long ? w_prod_fix[2*WIDTH-1] : w_fix_lo[WIDTH-1];
          r_z     <= w_long ? (w_prod_fix == '0) : (w_fix_lo == '0);
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mul_bus.busy      = (r_state == ST_RUN) || (r_state == ST_FIX);
  assign mul_bus.done      = r_done;
  assign mul_bus.result_lo = r_lo;
  assign mul_bus.result_hi = r_hi;
  assign mul_bus.flag_n    = r_n;
  assign mul_bus.flag_z    = r_z;

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: a radix-1 and a radix-4 instance, expected
// results from a direct 64-bit arithmetic model, latency from the build mode.
`timescale 1ns/1ps
module tb_mul_unit;
  import mul_pkg::*;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        n;
    logic        z;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   sel = 1'b0;     // 0: radix-1 instance, 1: radix-4 instance
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mul_unit_if #(.WIDTH(32)) bus_r1 ();
  mul_unit_if #(.WIDTH(32)) bus_r4 ();

  mul_unit #(.WIDTH(32), .RADIX_BITS(1)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .mul_bus (bus_r1)
  );

  mul_unit #(.WIDTH(32), .RADIX_BITS(4)) u_dut4 (
    .clk     (clk),
    .reset   (reset),
    .mul_bus (bus_r4)
  );

  logic        m_busy, m_done, m_n, m_z;
  logic [31:0] m_lo, m_hi;
  assign m_busy = sel ? bus_r4.busy      : bus_r1.busy;
  assign m_done = sel ? bus_r4.done      : bus_r1.done;
  assign m_lo   = sel ? bus_r4.result_lo : bus_r1.result_lo;
  assign m_hi   = sel ? bus_r4.result_hi : bus_r1.result_hi;
  assign m_n    = sel ? bus_r4.flag_n    : bus_r1.flag_n;
  assign m_z    = sel ? bus_r4.flag_z    : bus_r1.flag_z;

  function automatic exp_t model(input mul_op_e op, input logic [31:0] a, b, acc,
                                 input int radix);
    exp_t        e;
    logic [63:0] p;
    logic [31:0] mag;
    int          hb;
    case (op)
      MUL_OP_UMULL: p = {32'b0, a} * {32'b0, b};
      MUL_OP_SMULL: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      MUL_OP_MLA:   p = {32'b0, a * b + acc};
      default:      p = {32'b0, a * b};
    endcase
    if (op == MUL_OP_UMULL || op == MUL_OP_SMULL) begin
      e.lo = p[31:0];
      e.hi = p[63:32];
      e.n  = p[63];
      e.z  = (p == 64'd0);
    end else begin
      e.lo = p[31:0];
      e.hi = 32'd0;
      e.n  = p[31];
      e.z  = (p[31:0] == 32'd0);
    end
    mag = (op == MUL_OP_SMULL && b[31]) ? -b : b;
    hb  = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) hb = i;
`ifdef MUL_EARLY_OUT_EN
    e.lat = ((mag == 32'd0) ? 1 : (hb / radix + 1)) + 1;
`else
    e.lat = 32 / radix + 1;
`endif
    return e;
  endfunction

  // Called at a negedge: drives a request for one cycle and records its expectation.
  task automatic issue(input mul_op_e op, input logic [31:0] a, b, acc);
    bus_r1.op = op;  bus_r1.a = a;  bus_r1.b = b;  bus_r1.acc = acc;
    bus_r4.op = op;  bus_r4.a = a;  bus_r4.b = b;  bus_r4.acc = acc;
    if (sel) bus_r4.start = 1'b1;
    else     bus_r1.start = 1'b1;
    sb_q.push_back(model(op, a, b, acc, sel ? 4 : 1));
    @(negedge clk);
    bus_r1.start = 1'b0;
    bus_r4.start = 1'b0;
  endtask

  // Waits (bounded) for done, pops the oldest expectation and compares; returns at the done negedge.
  task automatic wait_result(input string name);
    exp_t e;
    int   lat = 0;
    int   busy_cnt = 0;
    while (m_done !== 1'b1 && lat < 200) begin
      if (m_busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (m_done !== 1'b1) $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, m_done, lat);
    else n_pass++;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s scoreboard: queue empty at done, required an entry", name);
      return;
    end
    e = sb_q.pop_front();
    n_checks++;
    if (lat !== e.lat) $display("FAIL %s latency: got %0d required %0d", name, lat, e.lat);
    else n_pass++;
    n_checks++;
    if (busy_cnt !== e.lat) $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cnt, e.lat);
    else n_pass++;
    n_checks++;
    if (m_busy !== 1'b0) $display("FAIL %s busy_at_done: got %b required 0", name, m_busy);
    else n_pass++;
    n_checks++;
    if (m_lo !== e.lo) $display("FAIL %s result_lo: got %h required %h", name, m_lo, e.lo);
    else n_pass++;
    n_checks++;
    if (m_hi !== e.hi) $display("FAIL %s result_hi: got %h required %h", name, m_hi, e.hi);
    else n_pass++;
    n_checks++;
    if (m_n !== e.n) $display("FAIL %s flag_n: got %b required %b", name, m_n, e.n);
    else n_pass++;
    n_checks++;
    if (m_z !== e.z) $display("FAIL %s flag_z: got %b required %b", name, m_z, e.z);
    else n_pass++;
  endtask

  task automatic test_reset();
    bus_r1.start = 1'b0; bus_r1.op = MUL_OP_MUL; bus_r1.a = '0; bus_r1.b = '0; bus_r1.acc = '0;
    bus_r4.start = 1'b0; bus_r4.op = MUL_OP_MUL; bus_r4.a = '0; bus_r4.b = '0; bus_r4.acc = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m_busy, m_done, m_n, m_z} !== 4'b0000)
      $display("FAIL reset_ctrl: busy/done/n/z=%b required 0000", {m_busy, m_done, m_n, m_z});
    else n_pass++;
    n_checks++;
    if ({m_hi, m_lo} !== 64'd0) $display("FAIL reset_result: got %h required 0", {m_hi, m_lo});
    else n_pass++;
  endtask

  task automatic test_mul();
    issue(MUL_OP_MUL, 32'd7, 32'd6, 32'd0);
    wait_result("mul_7x6");
    @(negedge clk);
    n_checks++;
    if (m_done !== 1'b0) $display("FAIL done_pulse: got %b one cycle later, required 0", m_done);
    else n_pass++;
  endtask

  task automatic test_long();
    issue(MUL_OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    wait_result("umull_max");
    issue(MUL_OP_SMULL, 32'h8000_0000, 32'h8000_0000, 32'd0);
    wait_result("smull_minmin");
    issue(MUL_OP_SMULL, 32'hFFFF_FFFF, 32'h0000_0002, 32'd0);
    wait_result("smull_neg");
  endtask

  task automatic test_back_to_back();
    issue(MUL_OP_MLA, 32'd3, 32'd4, 32'hFFFF_FFF4);
    wait_result("mla_wrap");
    issue(MUL_OP_MUL, 32'd2, 32'd2, 32'd0);
    n_checks++;
    if (m_lo !== 32'd0 || m_z !== 1'b1)
      $display("FAIL result_hold: lo=%h z=%b after accept, required lo=0 z=1", m_lo, m_z);
    else n_pass++;
    wait_result("b2b_mul");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] b_r;
      b_r = $urandom >> $urandom_range(0, 31);
      issue(mul_op_e'($urandom_range(0, 3)), $urandom, b_r, $urandom);
      wait_result($sformatf("random_%0d", i));
    end
  endtask

  task automatic test_busy_ignore();
    int   dones = 0;
    logic [31:0] lo_seen = 'x;
    exp_t e;
    issue(MUL_OP_MUL, 32'd7, 32'd6, 32'd0);
    for (int c = 0; c < 80; c++) begin
      if (bus_r1.done === 1'b1) begin
        dones++;
        lo_seen = bus_r1.result_lo;
      end
      if (bus_r1.busy === 1'b1) begin
        bus_r1.start = 1'b1;
        bus_r1.op    = mul_op_e'($urandom_range(0, 3));
        bus_r1.a     = $urandom;
        bus_r1.b     = $urandom;
      end else begin
        bus_r1.start = 1'b0;
      end
      @(negedge clk);
    end
    bus_r1.start = 1'b0;
    e = sb_q.pop_front();
    n_checks++;
    if (dones !== 1) $display("FAIL busy_ignore_dones: got %0d required 1", dones);
    else n_pass++;
    n_checks++;
    if (lo_seen !== e.lo) $display("FAIL busy_ignore_lo: got %h required %h", lo_seen, e.lo);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    issue(MUL_OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({m_busy, m_done, m_n, m_z} !== 4'b0000)
      $display("FAIL abort_ctrl: busy/done/n/z=%b required 0000", {m_busy, m_done, m_n, m_z});
    else n_pass++;
    n_checks++;
    if ({m_hi, m_lo} !== 64'd0) $display("FAIL abort_result: got %h required 0", {m_hi, m_lo});
    else n_pass++;
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (m_done === 1'b1) dones++;
      @(negedge clk);
    end
    n_checks++;
    if (dones !== 0) $display("FAIL abort_no_done: got %0d dones required 0", dones);
    else n_pass++;
    issue(MUL_OP_MUL, 32'd5, 32'd9, 32'd0);
    wait_result("after_abort");
  endtask

  task automatic test_radix4();
    sel = 1'b1;
    @(negedge clk);
    issue(MUL_OP_MUL, 32'd5, 32'h0000_FFFF, 32'd0);
    wait_result("r4_mul_ffff");
    issue(MUL_OP_SMULL, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    wait_result("r4_smull");
    issue(MUL_OP_UMULL, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0);
    wait_result("r4_umull");
    issue(MUL_OP_MLA, 32'd5, 32'd1, 32'd100);
    wait_result("r4_mla");
    sel = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_long();
    test_back_to_back();
    issue(MUL_OP_MUL, 32'd5, 32'd1, 32'd0);
    wait_result("mul_5x1");
    test_random();
    test_busy_ignore();
    test_reset_abort();
    test_radix4();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
